video_pattern_gen: RTL and testbench

//  Synthesizable, parametrised AXI4-Stream video source; successor to the Keystone bench stimulus loop.

---
 rtl/vpg_pkg.sv | 37 +++
 rtl/video_pattern_gen_if.sv | 13 +
 rtl/vpg_pixel_colour.sv | 44 ++++
 rtl/video_pattern_gen.sv | 188 ++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vpg_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern generator.
package vpg_pkg;

  typedef enum logic [1:0] {
    GRADIENT = 2'd0,
    BARS     = 2'd1,
    SOLID    = 2'd2,
    CHECKER  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Bar edges are j*width for j=1..7, compared against 8*x.
  localparam int unsigned EdgeW = 19;
  typedef logic [6:0][EdgeW-1:0] bar_edges_t;

  // Index 0 is the leftmost bar: W, Y, C, G, M, R, B, K.
  localparam pixel_t [7:0] BarLut = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [31:0] pack_pixel(pixel_t px);
    return {2'b00, px.r, 2'b00, px.b, 2'b00, px.g, 2'b00};
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// AXI4-Stream video bus carrying PPC 32-bit pixel words per beat.
interface video_pattern_gen_if #(
  parameter int unsigned PPC = 2
);
  logic [32*PPC-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/vpg_pixel_colour.sv
// Combinational colour of one pixel lane for the selected pattern.
module vpg_pixel_colour
  import vpg_pkg::*;
(
  input  pattern_e    mode_i,
  input  logic [31:0] n_i,
  input  logic [15:0] xp_i,
  input  logic [15:0] y_i,
  input  bar_edges_t  bar_edges_i,
  input  pixel_t      solid_i,
  output logic [31:0] word_o
);

  pixel_t           px;
  logic [2:0]       bar;
  logic [EdgeW-1:0] xp8;
  logic [15:0]      chk;

  assign xp8 = {xp_i, 3'b000};

  always_comb begin
    // Bar index = number of edges at or left of 8*x, i.e. floor(8x/width).
    bar = '0;
    for (int j = 0; j < 7; j++) begin
      if (xp8 >= bar_edges_i[j]) bar = bar + 3'd1;
    end
    chk = ((xp_i >> 5) ^ (y_i >> 5)) & 16'd1;
    px  = '0;
    case (mode_i)
      GRADIENT: begin
        px.r = 8'(32'hFF - n_i);
        px.g = 8'(32'hFF + n_i);
        px.b = 8'(32'hFF - (n_i << 1));
      end
      BARS:    px = BarLut[bar];
      SOLID:   px = solid_i;
      CHECKER: px = (chk != 16'd0) ? 24'hFFFFFF : 24'h000000;
      default: px = '0;
    endcase
  end

  assign word_o = pack_pixel(px);

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream video source: frame FSM, beat counters and registered output stage.
module video_pattern_gen
  import vpg_pkg::*;
#(
  parameter int unsigned PPC        = 2,
  parameter int unsigned MAX_W      = 1920,
  parameter int unsigned MAX_H      = 1080,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       aclken,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [15:0]                frame_width,
  input  logic [15:0]                frame_height,
  input  logic [23:0]                solid_rgb,
  video_pattern_gen_if.master        m_axis_video,
  output logic [31:0]                frame_count,
  output logic                       busy,
  output logic                       cfg_err
);

  state_e            state_q, state_d;
  pattern_e          mode_q, mode_sel;
  logic [15:0]       width_q, height_q, width_sel;
  pixel_t            solid_q, solid_sel;
  bar_edges_t        edges_q, edges_in, edges_sel;
  logic [15:0]       x_q, y_q, nx, ny;
  logic [31:0]       n_q, nn;
  logic [15:0]       gap_q, gap_d;
  logic [31:0]       fc_q, fc_d;
  logic              cfg_err_q, cfg_err_d;
  logic              tvalid_q, tvalid_d, tuser_q, tlast_q, nlast;
  logic [32*PPC-1:0] tdata_q, beat_data;
  logic              cfg_ok, xfer, last_beat, load, adv, restart;

  assign cfg_ok = (frame_width != 16'd0) && (frame_height != 16'd0) &&
                  (32'(frame_width) <= MAX_W) && (32'(frame_height) <= MAX_H) &&
                  ((32'(frame_width) % PPC) == 32'd0);

  assign xfer      = tvalid_q && m_axis_video.tready && aclken;
  assign last_beat = tlast_q && (y_q == height_q - 16'd1);

  always_comb begin
    edges_in = '0;
    for (int j = 0; j < 7; j++) begin
      edges_in[j] = EdgeW'(32'(j + 1) * 32'(frame_width));
    end
  end

  // On a latch the first beat must be built from the incoming config.
  assign mode_sel  = load ? pattern_e'(mode) : mode_q;
  assign width_sel = load ? frame_width : width_q;
  assign solid_sel = load ? pixel_t'(solid_rgb) : solid_q;
  assign edges_sel = load ? edges_in : edges_q;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    fc_d      = fc_q;
    cfg_err_d = cfg_err_q;
    tvalid_d  = tvalid_q;
    load      = 1'b0;
    adv       = 1'b0;
    restart   = 1'b0;
    if (aclken) begin
      case (state_q)
        IDLE: restart = enable;
        ACTIVE: begin
          if (xfer) begin
            if (last_beat) begin
              fc_d     = fc_q + 32'd1;
              tvalid_d = 1'b0;
              gap_d    = '0;
              if (GAP_CYCLES == 0) restart = 1'b1;
              else                 state_d = GAP;
            end else begin
              adv = 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_q == 16'(GAP_CYCLES - 1)) restart = 1'b1;
          else                              gap_d   = gap_q + 16'd1;
        end
        default: state_d = IDLE;
      endcase
      if (restart) begin
        if (enable && cfg_ok) begin
          load      = 1'b1;
          state_d   = ACTIVE;
          cfg_err_d = 1'b0;
          tvalid_d  = 1'b1;
        end else begin
          state_d = IDLE;
          if (enable) cfg_err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    nx = x_q;
    ny = y_q;
    nn = n_q;
    if (load) begin
      nx = '0;
      ny = '0;
      nn = '0;
    end else if (tlast_q) begin
      nx = '0;
      ny = y_q + 16'd1;
      nn = n_q + PPC;
    end else begin
      nx = x_q + 16'(PPC);
      nn = n_q + PPC;
    end
  end

  assign nlast = (17'(nx) + 17'(PPC)) == 17'(width_sel);

  for (genvar p = 0; p < PPC; p++) begin : g_lane
    vpg_pixel_colour u_colour (
      .mode_i      (mode_sel),
      .n_i         (nn + 32'(p)),
      .xp_i        (nx + 16'(p)),
      .y_i         (ny),
      .bar_edges_i (edges_sel),
      .solid_i     (solid_sel),
      .word_o      (beat_data[32*p +: 32])
    );
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      fc_q      <= '0;
      cfg_err_q <= 1'b0;
      tvalid_q  <= 1'b0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      mode_q    <= GRADIENT;
      width_q   <= '0;
      height_q  <= '0;
      solid_q   <= '0;
      edges_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
    end else if (aclken) begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      fc_q      <= fc_d;
      cfg_err_q <= cfg_err_d;
      tvalid_q  <= tvalid_d;
      if (load) begin
        mode_q   <= pattern_e'(mode);
        width_q  <= frame_width;
        height_q <= frame_height;
        solid_q  <= pixel_t'(solid_rgb);
        edges_q  <= edges_in;
      end
      if (load || adv) begin
        x_q     <= nx;
        y_q     <= ny;
        n_q     <= nn;
        tdata_q <= beat_data;
        tuser_q <= load;
        tlast_q <= nlast;
      end else if (!tvalid_d) begin
        tuser_q <= 1'b0;
        tlast_q <= 1'b0;
      end
    end
  end

  assign m_axis_video.tdata  = tdata_q;
  assign m_axis_video.tvalid = tvalid_q;
  assign m_axis_video.tuser  = tuser_q;
  assign m_axis_video.tlast  = tlast_q;
  assign frame_count         = fc_q;
  assign busy                = (state_q != IDLE);
  assign cfg_err             = cfg_err_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: frame format, patterns, config errors, gating, reset.
module tb_video_pattern_gen;

  localparam int unsigned PPC       = 2;
  localparam int unsigned GapCycles = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        aclken;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] frame_width;
  logic [15:0] frame_height;
  logic [23:0] solid_rgb;
  logic [31:0] frame_count;
  logic        busy;
  logic        cfg_err;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned cnt;

  video_pattern_gen_if #(.PPC(PPC)) vid ();

  video_pattern_gen #(
    .PPC        (PPC),
    .MAX_W      (1920),
    .MAX_H      (1080),
    .GAP_CYCLES (GapCycles)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .aclken       (aclken),
    .enable       (enable),
    .mode         (mode),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .solid_rgb    (solid_rgb),
    .m_axis_video (vid),
    .frame_count  (frame_count),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_px(input int unsigned m, input int unsigned n,
                                           input int unsigned xp, input int unsigned y,
                                           input int unsigned w, input logic [23:0] s);
    logic [7:0] r, g, b;
    int unsigned k;
    r = 8'h00;
    g = 8'h00;
    b = 8'h00;
    case (m)
      0: begin
        r = 8'(32'd255 - n);
        g = 8'(32'd255 + n);
        b = 8'(32'd255 - 32'd2 * n);
      end
      1: begin
        k = xp * 32'd8 / w;
        r = (((k / 32'd2) % 32'd2) == 32'd0) ? 8'hFF : 8'h00;
        g = (k < 32'd4) ? 8'hFF : 8'h00;
        b = ((k % 32'd2) == 32'd0) ? 8'hFF : 8'h00;
      end
      2: begin
        r = s[23:16];
        g = s[15:8];
        b = s[7:0];
      end
      default: begin
        if ((((xp >> 5) ^ (y >> 5)) & 32'd1) != 32'd0) begin
          r = 8'hFF;
          g = 8'hFF;
          b = 8'hFF;
        end
      end
    endcase
    return {2'b00, r, 2'b00, b, 2'b00, g, 2'b00};
  endfunction

  function automatic logic [63:0] model_beat(input int unsigned m, input int unsigned x,
                                             input int unsigned y, input int unsigned w,
                                             input logic [23:0] s);
    logic [63:0] d;
    int unsigned n;
    d = '0;
    n = y * w + x;
    for (int unsigned p = 0; p < PPC; p++) begin
      d[32*p +: 32] = model_px(m, n + p, x + p, y, w, s);
    end
    return d;
  endfunction

  task automatic set_cfg(input int unsigned m, input int unsigned w, input int unsigned h,
                         input logic [23:0] s);
    mode         = 2'(m);
    frame_width  = 16'(w);
    frame_height = 16'(h);
    solid_rgb    = s;
  endtask

  // Starts at a negedge; returns at the negedge where the final beat is presented with tready.
  task automatic run_frame(input string tag, input int unsigned m, input int unsigned w,
                           input int unsigned h, input logic [23:0] s, input bit rnd,
                           input int drop_line);
    int unsigned x = 0, y = 0, idle = 0;
    bit          stalled = 1'b0;
    logic [63:0] held_data;
    logic [2:0]  held_ctl;
    while (y < h) begin
      vid.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check($sformatf("%s_stall_data", tag), vid.tdata, held_data);
        check($sformatf("%s_stall_ctl", tag), 64'({vid.tvalid, vid.tuser, vid.tlast}),
              64'(held_ctl));
      end
      stalled = 1'b0;
      if (vid.tvalid && vid.tready) begin
        check($sformatf("%s_data_y%0d_x%0d", tag, y, x), vid.tdata, model_beat(m, x, y, w, s));
        check($sformatf("%s_sof_y%0d_x%0d", tag, y, x), 64'(vid.tuser),
              (x == 0 && y == 0) ? 64'd1 : 64'd0);
        check($sformatf("%s_eol_y%0d_x%0d", tag, y, x), 64'(vid.tlast),
              (x + PPC == w) ? 64'd1 : 64'd0);
        if (drop_line >= 0 && int'(y) == drop_line && x == 0) enable = 1'b0;
        idle = 0;
        x += PPC;
        if (x == w) begin
          x = 0;
          y++;
        end
      end else begin
        if (vid.tvalid) begin
          stalled   = 1'b1;
          held_data = vid.tdata;
          held_ctl  = {vid.tvalid, vid.tuser, vid.tlast};
        end
        idle++;
        if (idle > 200) begin
          check($sformatf("%s_timeout", tag), 64'd0, 64'd1);
          vid.tready = 1'b1;
          return;
        end
      end
      if (y < h) @(negedge aclk);
    end
    vid.tready = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned c = 0;
    while (busy && c < 300) begin
      @(negedge aclk);
      c++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    aresetn    = 1'b0;
    aclken     = 1'b1;
    enable     = 1'b0;
    vid.tready = 1'b1;
    set_cfg(0, 8, 2, 24'h0);
    repeat (3) @(negedge aclk);
    check("rst_tvalid", 64'(vid.tvalid), 64'd0);
    check("rst_tuser", 64'(vid.tuser), 64'd0);
    check("rst_tlast", 64'(vid.tlast), 64'd0);
    check("rst_tdata", vid.tdata, 64'd0);
    check("rst_fc", 64'(frame_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    aresetn = 1'b1;

    // 8x2 gradient, single frame, then the inter-frame gap
    enable = 1'b1;
    @(negedge aclk);
    check("t1_tvalid", 64'(vid.tvalid), 64'd1);
    check("t1_r0", 64'(vid.tdata[29:20]), 64'h3FC);
    check("t1_sof", 64'(vid.tuser), 64'd1);
    run_frame("t1", 0, 8, 2, 24'h0, 1'b0, 0);
    check("t1_fc_pre", 64'(frame_count), 64'd0);
    @(negedge aclk);
    check("t1_fc", 64'(frame_count), 64'd1);
    check("t1_gap_tvalid", 64'(vid.tvalid), 64'd0);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge aclk);
    end
    check("t1_gap_len", 64'(cnt), 64'(GapCycles));

    // Full-width gradient with random backpressure
    set_cfg(0, 1920, 4, 24'h0);
    enable = 1'b1;
    run_frame("t2", 0, 1920, 4, 24'h0, 1'b1, 0);
    wait_idle("t2_idle");
    check("t2_fc", 64'(frame_count), 64'd2);

    // Colour bars, 16x1
    set_cfg(1, 16, 1, 24'h0);
    enable = 1'b1;
    @(negedge aclk);
    check("t3_bar0", vid.tdata, 64'h3FCFF3FC_3FCFF3FC);
    run_frame("t3", 1, 16, 1, 24'h0, 1'b0, 0);
    wait_idle("t3_idle");
    check("t3_fc", 64'(frame_count), 64'd3);

    // Width not a multiple of PPC is rejected, then a valid width starts
    set_cfg(0, 7, 2, 24'h0);
    enable = 1'b1;
    repeat (2) @(negedge aclk);
    check("t4_cfg_err", 64'(cfg_err), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge aclk);
    check("t4_no_valid", 64'(vid.tvalid), 64'd0);
    frame_width = 16'd8;
    @(negedge aclk);
    check("t4_cfg_clr", 64'(cfg_err), 64'd0);
    check("t4_tvalid", 64'(vid.tvalid), 64'd1);
    run_frame("t4", 0, 8, 2, 24'h0, 1'b0, 0);
    wait_idle("t4_idle");
    check("t4_fc", 64'(frame_count), 64'd4);

    // Back-to-back solid frames; new colour takes effect only at the relatch
    set_cfg(2, 8, 1, 24'h123456);
    enable = 1'b1;
    run_frame("t5a", 2, 8, 1, 24'h123456, 1'b0, -1);
    solid_rgb = 24'hABCDEF;
    cnt = 0;
    @(negedge aclk);
    while (!vid.tvalid && cnt < 100) begin
      cnt++;
      @(negedge aclk);
    end
    check("t5_gap_len", 64'(cnt), 64'(GapCycles));
    run_frame("t5b", 2, 8, 1, 24'hABCDEF, 1'b0, 0);
    wait_idle("t5_idle");
    check("t5_fc", 64'(frame_count), 64'd6);

    // Checkerboard, enable dropped on line 1 of 4
    set_cfg(3, 64, 4, 24'h0);
    enable = 1'b1;
    run_frame("t6", 3, 64, 4, 24'h0, 1'b0, 1);
    wait_idle("t6_idle");
    check("t6_fc", 64'(frame_count), 64'd7);
    repeat (4) @(negedge aclk);
    check("t6_stays_idle", 64'(vid.tvalid), 64'd0);

    // Clock-enable freeze mid-line, then asynchronous reset mid-frame
    set_cfg(0, 64, 4, 24'h0);
    enable = 1'b1;
    repeat (3) @(negedge aclk);
    check("t7_beat2", vid.tdata, model_beat(0, 4, 0, 64, 24'h0));
    aclken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check($sformatf("t7_frz_data%0d", i), vid.tdata, model_beat(0, 4, 0, 64, 24'h0));
      check($sformatf("t7_frz_valid%0d", i), 64'(vid.tvalid), 64'd1);
    end
    aclken = 1'b1;
    @(negedge aclk);
    check("t7_beat3", vid.tdata, model_beat(0, 6, 0, 64, 24'h0));
    #2 aresetn = 1'b0;
    #1;
    check("t7_rst_tvalid", 64'(vid.tvalid), 64'd0);
    check("t7_rst_busy", 64'(busy), 64'd0);
    check("t7_rst_fc", 64'(frame_count), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    run_frame("t7", 0, 64, 4, 24'h0, 1'b0, 0);
    wait_idle("t7_idle");
    check("t7_fc", 64'(frame_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
